// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_HALT  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    // Word fetches require a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch and stall counters for the fetch controller.
// Only built when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_inc,
    input  logic               stall_inc,
    output logic [INSTR_W-1:0] fetch_count,
    output logic [INSTR_W-1:0] stall_count
);

    logic [INSTR_W-1:0] fetch_q, fetch_d;
    logic [INSTR_W-1:0] stall_q, stall_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        fetch_d = fetch_q;
        stall_d = stall_q;
        if (fetch_inc && (fetch_q != '1)) begin
            fetch_d = fetch_q + INSTR_W'(1);
        end
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + INSTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            stall_q <= stall_d;
        end
    end

    assign fetch_count = fetch_q;
    assign stall_count = stall_q;

endmodule
`endif

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC, fetch FSM and one-entry output stage toward decode.
// Define FETCH_PERF_CNT_EN to add the FetchCount/StallCount outputs.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] IMEM_BYTES  = 32'h0000_0028,
    parameter bit                 HALT_ON_NOP = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    output logic [INSTR_W-1:0] MemAddress,
    input  logic [INSTR_W-1:0] MemInstr,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [INSTR_W-1:0] PcOut,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic               Redirect,
    input  logic [INSTR_W-1:0] RedirectPc,
    output logic               Halted,
    output logic               Fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [INSTR_W-1:0] FetchCount,
    output logic [INSTR_W-1:0] StallCount
`endif
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;

    logic               pc_illegal_c;
    logic               redirect_bad_c;
    logic               load_c;
    logic               go_fault;

    assign pc_illegal_c   = (pc_q >= IMEM_BYTES) || is_misaligned(pc_q[1:0]);
    assign redirect_bad_c = is_misaligned(RedirectPc[1:0]);
    // Redirect and an illegal PC both pre-empt a load in RUN.
    assign load_c = (state_q == FS_RUN) && !Redirect && !pc_illegal_c && (!valid_q || InstrReady);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        go_fault = 1'b0;

        case (state_q)
            FS_IDLE: begin
                if (Start) begin
                    state_d = FS_RUN;
                end
            end
            FS_RUN: begin
                if (Redirect) begin
                    if (redirect_bad_c) begin
                        go_fault = 1'b1;
                    end else begin
                        pc_d    = RedirectPc;
                        valid_d = 1'b0;
                    end
                end else if (pc_illegal_c) begin
                    go_fault = 1'b1;
                end else if (load_c) begin
                    instr_d  = MemInstr;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + INSTR_W'(PC_STEP);
                    if (HALT_ON_NOP && (MemInstr == HALT_WORD)) begin
                        state_d  = FS_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            FS_HALT: begin
                if (Redirect) begin
                    if (redirect_bad_c) begin
                        go_fault = 1'b1;
                    end else begin
                        pc_d     = RedirectPc;
                        valid_d  = 1'b0;
                        halted_d = 1'b0;
                        state_d  = FS_RUN;
                    end
                end else if (valid_q && InstrReady) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase

        // PC is left at the offending value so it stays visible on MemAddress.
        if (go_fault) begin
            state_d  = FS_FAULT;
            fault_d  = 1'b1;
            valid_d  = 1'b0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= FS_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign MemAddress = pc_q;
    assign InstrOut   = instr_q;
    assign PcOut      = pc_out_q;
    assign InstrValid = valid_q;
    assign Halted     = halted_q;
    assign Fault      = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic stall_c;
    assign stall_c = (state_q == FS_RUN) && valid_q && !InstrReady;

    fetch_perf_cnt u_perf (
        .clk         (Clk),
        .rst         (Reset),
        .fetch_inc   (load_c),
        .stall_inc   (stall_c),
        .fetch_count (FetchCount),
        .stall_count (StallCount)
    );
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios plus randomized ready/redirect traffic.
module tb_imem_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, InstrReady, Redirect;
    logic [31:0] RedirectPc, MemAddress, MemInstr, InstrOut, PcOut;
    logic        InstrValid, Halted, Fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, StallCount;
`endif

    logic [31:0] prog [16];
    logic [31:0] sb_q [$];
    logic [31:0] mon_exp;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;

    always #5 Clk = ~Clk;

    // Behavioural instruction memory: combinational read of the program image.
    assign MemInstr = (MemAddress < 32'h28) ? prog[MemAddress[5:2]] : 32'hDEAD_BEEF;

    imem_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_BYTES  (32'h0000_0028),
        .HALT_ON_NOP (1'b1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .MemAddress (MemAddress),
        .MemInstr   (MemInstr),
        .InstrOut   (InstrOut),
        .PcOut      (PcOut),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Redirect   (Redirect),
        .RedirectPc (RedirectPc),
        .Halted     (Halted),
        .Fault      (Fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount (FetchCount),
        .StallCount (StallCount)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Expected delivery order from a start address: sequential words up to and including the halt word.
    function automatic void push_stream(input logic [31:0] start);
        for (int a = int'(start); a < 40; a += 4) begin
            sb_q.push_back(32'(a));
            if (prog[a / 4] == 32'h0) break;
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en     = 1'b0;
        sb_q.delete();
        Reset      = 1'b1;
        Start      = 1'b0;
        Redirect   = 1'b0;
        RedirectPc = 32'h0;
        InstrReady = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 80 && !Halted; i++) tick();
        chk(name, 32'(Halted), 32'd1);
    endtask

    // Monitor: every transfer must match the head of the expected stream; a redirect restarts the stream.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (InstrValid && InstrReady) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_transfer: got pc %h, expected no transfer", PcOut);
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("xfer_pc", PcOut, mon_exp);
                    chk("xfer_instr", InstrOut, prog[mon_exp[5:2]]);
                end
            end
            if (Redirect) begin
                sb_q.delete();
                push_stream(RedirectPc);
            end
        end
    end

    initial begin
        prog[0] = 32'h2002_0001; prog[1] = 32'h0002_1822; prog[2] = 32'h0060_282a;
        prog[3] = 32'h00a4_3020; prog[4] = 32'h00c5_3822; prog[5] = 32'h00e6_4024;
        prog[6] = 32'h0107_4824; prog[7] = 32'hac89_0000; prog[8] = 32'h8c09_0020;
        prog[9] = 32'h0000_0000;
        for (int i = 10; i < 16; i++) prog[i] = 32'hFFFF_0000 | 32'(i);

        // Reset state, and Redirect ignored while idle
        do_reset();
        chk("rst_instr", InstrOut, 32'h0);
        chk("rst_pcout", PcOut, 32'h0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        chk("rst_addr", MemAddress, 32'h0);
        Redirect = 1'b1; RedirectPc = 32'h18;
        tick();
        Redirect = 1'b0;
        chk("idle_redirect_addr", MemAddress, 32'h0);
        chk("idle_redirect_valid", 32'(InstrValid), 32'd0);

        // Straight-line run to the halt word
        do_reset();
        mon_en = 1'b1; push_stream(32'h0);
        Start = 1'b1; InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        chk("lat_valid_e1", 32'(InstrValid), 32'd0);
        tick();
        chk("lat_valid_e2", 32'(InstrValid), 32'd1);
        chk("lat_pcout_e2", PcOut, 32'h0);
        wait_halt("line_halted");
        tick();
        chk("line_valid_after_halt", 32'(InstrValid), 32'd0);
        chk("line_addr_stop", MemAddress, 32'h28);
        repeat (3) tick();
        chk("line_pcout_last", PcOut, 32'h24);
        chk("line_valid_idle", 32'(InstrValid), 32'd0);
        chk("line_sb_empty", 32'(sb_q.size()), 32'd0);

        // Back-pressure at PcOut=0x08
        do_reset();
        mon_en = 1'b1; push_stream(32'h0);
        Start = 1'b1; InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("bp_pcout", PcOut, 32'h08);
        InstrReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_instr", InstrOut, 32'h0060_282a);
            chk("bp_hold_addr", MemAddress, 32'h0C);
            chk("bp_hold_valid", 32'(InstrValid), 32'd1);
        end
        InstrReady = 1'b1;
        tick();
        chk("bp_resume_pc", PcOut, 32'h0C);
        wait_halt("bp_halted");
        tick();
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", FetchCount, 32'd10);
        chk("perf_stall", StallCount, 32'd3);
`endif

        // Redirect while PcOut=0x04 is valid and being accepted
        do_reset();
        mon_en = 1'b1; push_stream(32'h0);
        Start = 1'b1; InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick();
        chk("rd_pcout_before", PcOut, 32'h04);
        Redirect = 1'b1; RedirectPc = 32'h18;
        tick();
        Redirect = 1'b0;
        chk("rd_flush_valid", 32'(InstrValid), 32'd0);
        chk("rd_addr", MemAddress, 32'h18);
        tick();
        chk("rd_pcout", PcOut, 32'h18);
        chk("rd_instr", InstrOut, 32'h0107_4824);
        wait_halt("rd_halted");
        tick();
        chk("rd_sb_empty", 32'(sb_q.size()), 32'd0);

        // Misaligned redirect target
        do_reset();
        Start = 1'b1; InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Redirect = 1'b1; RedirectPc = 32'h1A;
        tick();
        Redirect = 1'b0;
        chk("fa_fault", 32'(Fault), 32'd1);
        chk("fa_valid", 32'(InstrValid), 32'd0);
        chk("fa_halted", 32'(Halted), 32'd0);
        repeat (3) tick();
        chk("fa_sticky", 32'(Fault), 32'd1);

        // Redirect to the first illegal address
        do_reset();
        Start = 1'b1; InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Redirect = 1'b1; RedirectPc = 32'h28;
        tick();
        Redirect = 1'b0;
        chk("fb_no_fault_yet", 32'(Fault), 32'd0);
        chk("fb_addr", MemAddress, 32'h28);
        tick();
        chk("fb_fault", 32'(Fault), 32'd1);
        chk("fb_valid", 32'(InstrValid), 32'd0);
        Start = 1'b1;
        repeat (3) tick();
        chk("fb_sticky", 32'(Fault), 32'd1);
        chk("fb_pc_frozen", MemAddress, 32'h28);
        Start = 1'b0;
        Reset = 1'b1;
        #1;
        chk("fb_reset_clears", 32'(Fault), 32'd0);
        tick();
        Reset = 1'b0;

        // Asynchronous reset between edges while a word is valid
        do_reset();
        Start = 1'b1; InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick();
        chk("mr_valid_before", 32'(InstrValid), 32'd1);
        #3;
        Reset = 1'b1;
        #1;
        chk("mr_valid", 32'(InstrValid), 32'd0);
        chk("mr_instr", InstrOut, 32'h0);
        chk("mr_pcout", PcOut, 32'h0);
        chk("mr_addr", MemAddress, 32'h0);
        tick(); tick();
        Reset = 1'b0;
        repeat (3) tick();
        chk("mr_idle_valid", 32'(InstrValid), 32'd0);
        chk("mr_idle_addr", MemAddress, 32'h0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        chk("mr_restart_valid", 32'(InstrValid), 32'd1);
        chk("mr_restart_pc", PcOut, 32'h0);

        // Randomized ready and in-range redirects
        do_reset();
        mon_en = 1'b1; push_stream(32'h0);
        Start = 1'b1; InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            InstrReady = ($urandom_range(3) != 0);
            Redirect   = ($urandom_range(11) == 0);
            RedirectPc = 32'($urandom_range(9)) << 2;
            tick();
        end
        Redirect = 1'b0; InstrReady = 1'b1;
        for (int i = 0; i < 80 && !(Halted && !InstrValid); i++) tick();
        chk("rand_halted", 32'(Halted), 32'd1);
        chk("rand_drained", 32'(InstrValid), 32'd0);
        chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("rand_no_fault", 32'(Fault), 32'd0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the combinational instruction memory: holds the program counter, drives the memory address, and registers each returned word into a one-entry output stage.
- The output stage has a valid/ready handshake toward decode.
- Handles start, redirect (branch/jump), halt on a sentinel word, and fault on an illegal PC.
- Sits between the instruction memory and the decode stage of the MIPS32 core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 32'h28, size of the populated instruction space in bytes; a PC at or above this is illegal.
- HALT_ON_NOP, 1, when 1 a fetched word equal to HALT_WORD stops fetching after it is delivered.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; leaves IDLE.
- MemAddress  out  32  address to instruction memory; always equals PC (combinational).
- MemInstr  in  32  word returned combinationally by instruction memory in the same cycle.
- InstrOut  out  32  registered instruction to decode.
- PcOut  out  32  PC of InstrOut.
- InstrValid  out  1  InstrOut/PcOut are valid.
- InstrReady  in  1  decode accepts; transfer occurs when InstrValid && InstrReady.
- Redirect  in  1  single-cycle pulse requesting a branch/jump target.
- RedirectPc  in  32  target address, sampled when Redirect=1.
- Halted  out  1  registered; high in HALT.
- Fault  out  1  registered, sticky until Reset.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - PC=RESET_PC; state=IDLE.
  - InstrOut=0, PcOut=0, InstrValid=0, Halted=0, Fault=0.
- States: IDLE, RUN, HALT, FAULT (2-bit encoding).
- IDLE:
  - No loads.
  - Start=1 moves to RUN on the next edge.
  - Redirect is ignored.
- RUN, in priority order each cycle:
  1. Redirect=1:
     - If RedirectPc[1:0]!=0, go to FAULT.
     - Otherwise PC<=RedirectPc and InstrValid<=0 (flush the held word, even one being transferred this cycle; decode owns consistency).
     - No load this cycle.
  2. PC>=IMEM_BYTES or PC[1:0]!=0: go to FAULT; no load.
  3. Load condition (!InstrValid || InstrReady):
     - InstrOut<=MemInstr, PcOut<=PC, InstrValid<=1, PC<=PC+4 (32-bit modulo wrap).
     - If HALT_ON_NOP && MemInstr==HALT_WORD, go to HALT.
  4. Otherwise (InstrValid && !InstrReady): hold PC, InstrOut, PcOut and InstrValid unchanged.
- Throughput and latency:
  - One instruction per cycle under continuous InstrReady.
  - First InstrValid is 2 cycles after Start is sampled: the RUN entry edge, then the load edge.
- HALT:
  - Halted=1; no further loads.
  - The halt word stays valid until accepted, then InstrValid<=0.
  - Redirect with an aligned target: PC<=RedirectPc, Halted<=0, go to RUN.
  - Redirect with a misaligned target goes to FAULT.
- FAULT:
  - Fault=1, InstrValid=0, Halted=0.
  - PC frozen at the offending value, visible on MemAddress.
  - Exit only by Reset.
- Start is ignored outside IDLE.
- Simultaneous Redirect and a transfer: the transfer completes on the decode side; the PC redirect wins.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds outputs FetchCount[31:0] and StallCount[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - FetchCount increments on each load.
  - StallCount increments each RUN cycle with InstrValid && !InstrReady.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - state enum: FS_IDLE, FS_RUN, FS_HALT, FS_FAULT.
  - HALT_WORD=32'h0000_0000.
  - INSTR_W=32, PC_STEP=4.
- One sub-module, fetch_perf_cnt (the two saturating counters), instantiated only under FETCH_PERF_CNT_EN.
- PC, FSM and output register stay in the top module.

Test Plan:
- Straight-line run:
  - Stimulus: memory holds 20020001, 00021822, ..., ac890000, 8c090020, 00000000 at 0x00..0x24; Start=1, InstrReady=1.
  - Response: ten transfers with PcOut 0x00..0x24 in order, then Halted=1 and InstrValid=0; no fetch beyond 0x24.
- Back-pressure:
  - Stimulus: InstrReady=0 for 3 cycles while InstrValid=1 at PcOut=0x08.
  - Response: InstrOut=0060282a and MemAddress=0x0C held stable; resumes at 0x0C when ready returns.
- Redirect:
  - Stimulus: Redirect=1 with RedirectPc=0x18 while PcOut=0x04 is valid.
  - Response: next cycle InstrValid=0; following cycle PcOut=0x18, InstrOut=01074824.
- Faults:
  - Stimulus and response: RedirectPc=0x1A gives Fault=1 next edge; Redirect to 0x28 gives Fault=1 one cycle after PC=0x28.
  - Fault stays high until Reset.
- Mid-run reset:
  - Stimulus: assert Reset asynchronously between edges while InstrValid=1.
  - Response: all outputs 0 immediately, PC=RESET_PC, state IDLE; Start is required to restart.
- Perf counters (FETCH_PERF_CNT_EN defined):
  - Stimulus: the back-pressure scenario run to completion.
  - Response: FetchCount=10, StallCount=3.
